// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Default 640x480@60 raster constants and helper functions shared
//            by the VGA timing generator and its axis counters.
// Revision : 1.0  initial parametrised release
// ============================================================================
package vga_timing_pkg;

    // Default 640x480@60 horizontal timing, in pixels
    localparam int unsigned c_H_ACTIVE = 640;
    localparam int unsigned c_H_FP     = 16;
    localparam int unsigned c_H_SYNC   = 96;
    localparam int unsigned c_H_BP     = 48;

    // Default 640x480@60 vertical timing, in lines
    localparam int unsigned c_V_ACTIVE = 480;
    localparam int unsigned c_V_FP     = 10;
    localparam int unsigned c_V_SYNC   = 2;
    localparam int unsigned c_V_BP     = 33;

    // Coordinate width that holds the default totals (800 and 525)
    localparam int unsigned c_CW          = 11;
    localparam int unsigned c_FRAME_CNT_W = 16;

    // Total period of one axis: visible region plus both porches and sync
    function automatic int unsigned calc_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    // Smallest coordinate width able to represent 0..total-1
    function automatic int unsigned calc_min_cw(input int unsigned total);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < total) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_cnt.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_cnt
// Brief    : One raster axis: position counter with explicit wrap at TOTAL-1,
//            registered sync decode and an active-region decode of the
//            position that will be held after the current edge.
// Revision : 1.0  initial parametrised release
// ============================================================================
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = c_H_ACTIVE,
    parameter int unsigned FP     = c_H_FP,
    parameter int unsigned SYNC   = c_H_SYNC,
    parameter int unsigned BP     = c_H_BP,
    parameter bit          POL    = 1'b0,
    parameter int unsigned CW     = c_CW
) (
    input  logic          pixel_clk,
    input  logic          rst,
    input  logic          i_step,
    output logic [CW-1:0] o_pos,
    output logic          o_sync,
    output logic          o_atLast,
    output logic          o_activeNext
);

    localparam int unsigned   c_TOTAL      = calc_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] c_LAST       = CW'(c_TOTAL - 1);
    localparam logic [CW-1:0] c_ACTIVE_END = CW'(ACTIVE);
    localparam logic [CW-1:0] c_SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] c_SYNC_END   = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] r_pos;
    logic          r_sync;
    logic [CW-1:0] w_posNext;
    logic          w_atLast;
    logic          w_syncNext;

    // Next position: explicit compare against the last position for the wrap
    always_comb begin
        w_atLast  = (r_pos == c_LAST);
        w_posNext = r_pos;
        if (i_step) begin
            w_posNext = w_atLast ? '0 : (r_pos + CW'(1));
        end
        w_syncNext = (w_posNext >= c_SYNC_START) && (w_posNext < c_SYNC_END);
    end

    // Position and sync register; reset parks on the last back-porch position
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_pos  <= c_LAST;
            r_sync <= ~POL;
        end else if (i_step) begin
            r_pos  <= w_posNext;
            r_sync <= w_syncNext ? POL : ~POL;
        end
    end

    assign o_pos        = r_pos;
    assign o_sync       = r_sync;
    assign o_atLast     = w_atLast;
    assign o_activeNext = (w_posNext < c_ACTIVE_END);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA raster timing generator. Registered h/v sync
//            with selectable polarity, display enable, pixel coordinates,
//            line/frame start strobes and an optional frame counter, all
//            advancing only on clock-enable edges.
//            Build option: define VGA_TIMING_FRAME_CNT_EN to build the live
//            16-bit frame counter; otherwise frame_cnt is tied to zero.
// Revision : 1.0  initial parametrised release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = c_H_ACTIVE,
    parameter int unsigned H_FP     = c_H_FP,
    parameter int unsigned H_SYNC   = c_H_SYNC,
    parameter int unsigned H_BP     = c_H_BP,
    parameter int unsigned V_ACTIVE = c_V_ACTIVE,
    parameter int unsigned V_FP     = c_V_FP,
    parameter int unsigned V_SYNC   = c_V_SYNC,
    parameter int unsigned V_BP     = c_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = c_CW
) (
    input  logic                     pixel_clk,
    input  logic                     rst,
    input  logic                     ce,
    output logic                     vga_h_sync,
    output logic                     vga_v_sync,
    output logic                     in_display_area,
    output logic [CW-1:0]            counter_x,
    output logic [CW-1:0]            counter_y,
    output logic                     line_start,
    output logic                     frame_start,
    output logic [c_FRAME_CNT_W-1:0] frame_cnt
);

    logic w_hLast;
    logic w_vLast;
    logic w_vStep;
    logic w_hActNext;
    logic w_vActNext;
    logic w_frameWrap;

    logic r_de;
    logic r_lineStart;
    logic r_frameStart;

    // The vertical axis only moves on the pixel that wraps the line
    assign w_vStep     = ce & w_hLast;
    assign w_frameWrap = w_hLast & w_vLast;

    vga_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .CW     (CW)
    ) u_h_axis (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .i_step       (ce),
        .o_pos        (counter_x),
        .o_sync       (vga_h_sync),
        .o_atLast     (w_hLast),
        .o_activeNext (w_hActNext)
    );

    vga_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .CW     (CW)
    ) u_v_axis (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .i_step       (w_vStep),
        .o_pos        (counter_y),
        .o_sync       (vga_v_sync),
        .o_atLast     (w_vLast),
        .o_activeNext (w_vActNext)
    );

    // Display enable and strobes, decoded from the position being loaded
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_de         <= 1'b0;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else if (ce) begin
            r_de         <= w_hActNext & w_vActNext;
            r_lineStart  <= w_hLast;
            r_frameStart <= w_frameWrap;
        end
    end

    assign in_display_area = r_de;
    assign line_start      = r_lineStart;
    assign frame_start     = r_frameStart;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [c_FRAME_CNT_W-1:0] r_frameCnt;
    logic                     r_frameSeen;

    // Count frame starts, skipping the first one after reset
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_frameCnt  <= '0;
            r_frameSeen <= 1'b0;
        end else if (ce && w_frameWrap) begin
            if (r_frameSeen) begin
                r_frameCnt <= r_frameCnt + c_FRAME_CNT_W'(1);
            end
            r_frameSeen <= 1'b1;
        end
    end

    assign frame_cnt = r_frameCnt;
`else
    assign frame_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Scoreboard bench for vga_timing_gen. Drives random ce/rst into a
//            default 640x480 instance and a tiny positive-polarity instance,
//            predicts outputs from raster position arithmetic, and compares
//            every cycle in a separate monitor process.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [10:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } out_t;

    logic pixel_clk = 1'b0;
    logic rst       = 1'b1;
    logic ce        = 1'b0;

    logic        hsA, vsA, deA, lsA, fsA;
    logic [10:0] xA, yA;
    logic [15:0] fcA;
    logic        hsB, vsB, deB, lsB, fsB;
    logic [10:0] xB, yB;
    logic [15:0] fcB;

    always #5 pixel_clk = ~pixel_clk;

    vga_timing_gen u_dutA (
        .pixel_clk       (pixel_clk),
        .rst             (rst),
        .ce              (ce),
        .vga_h_sync      (hsA),
        .vga_v_sync      (vsA),
        .in_display_area (deA),
        .counter_x       (xA),
        .counter_y       (yA),
        .line_start      (lsA),
        .frame_start     (fsA),
        .frame_cnt       (fcA)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b1), .CW (11)
    ) u_dutB (
        .pixel_clk       (pixel_clk),
        .rst             (rst),
        .ce              (ce),
        .vga_h_sync      (hsB),
        .vga_v_sync      (vsB),
        .in_display_area (deB),
        .counter_x       (xB),
        .counter_y       (yB),
        .line_start      (lsB),
        .frame_start     (fsB),
        .frame_cnt       (fcB)
    );

    // Mode table for the reference model: index 0 = default, 1 = tiny
    int unsigned HA[2] = '{640, 4};
    int unsigned HF[2] = '{16, 1};
    int unsigned HS[2] = '{96, 2};
    int unsigned HB[2] = '{48, 1};
    int unsigned VA[2] = '{480, 3};
    int unsigned VF[2] = '{10, 1};
    int unsigned VS[2] = '{2, 1};
    int unsigned VB[2] = '{33, 1};
    bit          HP[2] = '{1'b0, 1'b1};
    bit          VP[2] = '{1'b0, 1'b1};

    // Reference position and frame state per mode
    int unsigned mx[2];
    int unsigned my[2];
    int unsigned mfc[2];
    bit          mseen[2];

    out_t qA[$];
    out_t qB[$];

    int checks = 0;
    int errors = 0;

    // Advance the behavioural raster by one clock edge
    task automatic model_edge(input int m, input bit r, input bit c);
        int unsigned ht;
        int unsigned vt;
        ht = HA[m] + HF[m] + HS[m] + HB[m];
        vt = VA[m] + VF[m] + VS[m] + VB[m];
        if (r) begin
            mx[m]    = ht - 1;
            my[m]    = vt - 1;
            mfc[m]   = 0;
            mseen[m] = 1'b0;
        end else if (c) begin
            mx[m] = (mx[m] + 1) % ht;
            if (mx[m] == 0) begin
                my[m] = (my[m] + 1) % vt;
                if (my[m] == 0) begin
                    if (mseen[m]) mfc[m] = (mfc[m] + 1) % 65536;
                    mseen[m] = 1'b1;
                end
            end
        end
    endtask

    // Outputs implied by the reference position
    function automatic out_t model_out(input int m);
        out_t o;
        bit   hin;
        bit   vin;
        hin  = (mx[m] >= HA[m] + HF[m]) && (mx[m] < HA[m] + HF[m] + HS[m]);
        vin  = (my[m] >= VA[m] + VF[m]) && (my[m] < VA[m] + VF[m] + VS[m]);
        o.hs = hin ? HP[m] : ~HP[m];
        o.vs = vin ? VP[m] : ~VP[m];
        o.de = (mx[m] < HA[m]) && (my[m] < VA[m]);
        o.x  = 11'(mx[m]);
        o.y  = 11'(my[m]);
        o.ls = (mx[m] == 0);
        o.fs = (mx[m] == 0) && (my[m] == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        o.fc = 16'(mfc[m]);
`else
        o.fc = 16'd0;
`endif
        return o;
    endfunction

    // Apply inputs for the coming edge and queue the predicted result
    task automatic drive(input bit r, input bit c);
        rst = r;
        ce  = c;
        for (int m = 0; m < 2; m++) model_edge(m, r, c);
        qA.push_back(model_out(0));
        qB.push_back(model_out(1));
    endtask

    task automatic report(input string name, input out_t a, input out_t e);
        $display("FAIL %s t=%0t actual: x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d required: x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                 name, $time, a.x, a.y, a.hs, a.vs, a.de, a.ls, a.fs, a.fc,
                 e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs, e.fc);
    endtask

    // Monitor: one output sample per edge, compared against the scoreboard
    initial begin
        out_t actA;
        out_t actB;
        out_t expA;
        out_t expB;
        forever begin
            @(posedge pixel_clk);
            #1;
            actA = '{hs: hsA, vs: vsA, de: deA, x: xA, y: yA, ls: lsA, fs: fsA, fc: fcA};
            actB = '{hs: hsB, vs: vsB, de: deB, x: xB, y: yB, ls: lsB, fs: fsB, fc: fcB};
            checks++;
            if (qA.size() == 0 || qB.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow t=%0t actual: empty queue required: queued prediction", $time);
            end else begin
                expA = qA.pop_front();
                expB = qB.pop_front();
                if (actA !== expA) begin
                    errors++;
                    report("default_mode", actA, expA);
                end
                checks++;
                if (actB !== expB) begin
                    errors++;
                    report("tiny_mode", actB, expB);
                end
            end
        end
    end

    // Stimulus: reset, free run, ce toggling, random ce with reset pulses
    initial begin
        drive(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge pixel_clk);
            drive(1'b1, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 2500; i++) begin
            @(negedge pixel_clk);
            drive(i == 1300, 1'b1);
        end
        for (int i = 0; i < 1700; i++) begin
            @(negedge pixel_clk);
            drive(1'b0, 1'(i % 2 == 0));
        end
        for (int i = 0; i < 2500; i++) begin
            @(negedge pixel_clk);
            drive($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge pixel_clk);
            drive(1'b0, 1'b1);
        end
        @(posedge pixel_clk);
        #2;
        checks++;
        if (qA.size() != 0 || qB.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual: %0d/%0d left required: 0/0", qA.size(), qB.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
